// File: rtl/id_extend_if.sv
// id_extend_if
//  Handshake bundle for the decode-stage immediate-extend slot.
//  Upstream side (IF/ID): in_valid, instr, in_ready.
//  Downstream side (ID/EX): out_valid, out_ready and the decoded fields
//  extendSelect, imm_ext, out_opcode, out_rs, out_rt, out_rd.
//  slave  : the slot controller (consumes instr, produces decoded fields)
//  master : the environment driving instr and out_ready
interface id_extend_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic              out_valid;
   logic              out_ready;
   logic              extendSelect;
   logic [DATA_W-1:0] imm_ext;
   logic [5:0]        out_opcode;
   logic [4:0]        out_rs;
   logic [4:0]        out_rt;
   logic [4:0]        out_rd;

   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, extendSelect, imm_ext,
             out_opcode, out_rs, out_rt, out_rd
   );

   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, extendSelect, imm_ext,
             out_opcode, out_rs, out_rt, out_rd
   );
endinterface

// File: rtl/id_extend_ctrl.sv
// id_extend_ctrl
//  Decode-stage controller for the immediate-extend path. Holds one
//  instruction in a single-entry slot between IF/ID and ID/EX, decodes the
//  extend mode, captures the extended immediate and the register fields,
//  and withholds the instruction while a load in EX writes one of its
//  source registers (load-use bubble).
//  Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   bus          id_extend_if slave: in/out valid-ready handshakes + fields
//   flush        discard the held and the incoming instruction
//   ex_memRead   instruction in EX is a load
//   ex_rt        destination register of that load
//   bubble_cnt   saturating count of bubble cycles inserted
module id_extend_ctrl #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   id_extend_if.slave       bus,
   input  logic             flush,
   input  logic             ex_memRead,
   input  logic [4:0]       ex_rt,
   output logic [CNT_W-1:0] bubble_cnt
);

   // Slot state: EMPTY when full_q=0. HELD vs STALL is not stored; it is
   // the combinational hazard term, since EX can change under a held instr.
   logic              full_q, full_d;
   logic              sel_q, sel_d;
   logic [DATA_W-1:0] imm_ext_q, imm_ext_d;
   logic [5:0]        op_q, op_d;
   logic [4:0]        rs_q, rs_d;
   logic [4:0]        rt_q, rt_d;
   logic [4:0]        rd_q, rd_d;
   logic [CNT_W-1:0]  bcnt_q, bcnt_d;

   logic              hazard;
   logic              accept;
   logic              drain;
   logic [5:0]        op_in;
   logic [IMM_W-1:0]  imm_in;
   logic              sel_in;
   logic [DATA_W-1:0] ext_in;

   // Extend decode of the incoming word
   always_comb begin
      op_in  = bus.instr[31:26];
      imm_in = bus.instr[IMM_W-1:0];
      sel_in = 1'b1;
      ext_in = {{(DATA_W-IMM_W){imm_in[IMM_W-1]}}, imm_in};
      case (op_in)
         6'h0C, 6'h0D, 6'h0E: begin   // andi / ori / xori
            sel_in = 1'b0;
            ext_in = DATA_W'(imm_in);
         end
         6'h0F: begin                 // lui: immediate lands in upper half
            sel_in = 1'b0;
            ext_in = DATA_W'(imm_in) << IMM_W;
         end
         default: ;
      endcase
   end

   // Handshake and next-state
   always_comb begin
      // $0 is hard-wired zero, so a load targeting it never creates a hazard
      hazard = full_q & ex_memRead & (ex_rt != 5'd0) &
               ((ex_rt == rs_q) | (ex_rt == rt_q));
      bus.out_valid = full_q & ~hazard;
      bus.in_ready  = ~full_q | (bus.out_ready & ~hazard);
      accept = bus.in_valid & bus.in_ready & ~flush;
      drain  = bus.out_valid & bus.out_ready;

      full_d    = full_q;
      sel_d     = sel_q;
      imm_ext_d = imm_ext_q;
      op_d      = op_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;

      if (flush) begin
         full_d = 1'b0;
      end else if (accept) begin
         // Covers drain+accept in the same cycle: slot refilled, no idle gap
         full_d    = 1'b1;
         sel_d     = sel_in;
         imm_ext_d = ext_in;
         op_d      = op_in;
         rs_d      = bus.instr[25:21];
         rt_d      = bus.instr[20:16];
         rd_d      = bus.instr[15:11];
      end else if (drain) begin
         full_d = 1'b0;
      end

      bcnt_d = bcnt_q;
      if (hazard && !flush && bcnt_q != {CNT_W{1'b1}})
         bcnt_d = bcnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q    <= 1'b0;
         sel_q     <= 1'b0;
         imm_ext_q <= '0;
         op_q      <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         bcnt_q    <= '0;
      end else begin
         full_q    <= full_d;
         sel_q     <= sel_d;
         imm_ext_q <= imm_ext_d;
         op_q      <= op_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         bcnt_q    <= bcnt_d;
      end
   end

   assign bus.extendSelect = sel_q;
   assign bus.imm_ext      = imm_ext_q;
   assign bus.out_opcode   = op_q;
   assign bus.out_rs       = rs_q;
   assign bus.out_rt       = rt_q;
   assign bus.out_rd       = rd_q;
   assign bubble_cnt       = bcnt_q;

endmodule

// File: tb/tb_id_extend_ctrl.sv
// tb_id_extend_ctrl
//  Directed stimulus with hand-computed expectations. Every instruction
//  expected to leave the slot is queued; a negedge monitor pops and compares
//  on each out_valid & out_ready.
module tb_id_extend_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       ex_memRead;
   logic [4:0] ex_rt;
   logic [7:0] bubble_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic        sel;
      logic [31:0] imm;
   } exp_t;

   exp_t q[$];

   id_extend_if #(.DATA_W(32)) bus ();

   id_extend_ctrl #(.DATA_W(32), .IMM_W(16), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .flush      (flush),
      .ex_memRead (ex_memRead),
      .ex_rt      (ex_rt),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present ins until it is taken (bounded); optionally queue its expectation.
   task automatic send(input logic [31:0] ins, input logic sel,
                       input logic [31:0] imm, input bit push);
      bit   got;
      exp_t e;
      got = 1'b0;
      if (push) begin
         e.instr = ins; e.sel = sel; e.imm = imm;
         q.push_back(e);
      end
      bus.in_valid = 1'b1;
      bus.instr    = ins;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = bus.in_ready && !flush;
         @(posedge clk);
         #1;
      end
      if (!got) chk("send_timeout", 32'd0, 32'd1);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] w;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_output", {26'd0, bus.out_opcode}, 32'hFFFFFFFF);
         end else begin
            e = q.pop_front();
            w = e.instr;
            chk("sb_extendSelect", {31'd0, bus.extendSelect}, {31'd0, e.sel});
            chk("sb_imm_ext", bus.imm_ext, e.imm);
            chk("sb_opcode", {26'd0, bus.out_opcode}, {26'd0, w[31:26]});
            chk("sb_rs", {27'd0, bus.out_rs}, {27'd0, w[25:21]});
            chk("sb_rt", {27'd0, bus.out_rt}, {27'd0, w[20:16]});
            chk("sb_rd", {27'd0, bus.out_rd}, {27'd0, w[15:11]});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; ex_memRead = 1'b0; ex_rt = 5'd0;
      bus.in_valid = 1'b0; bus.instr = 32'd0; bus.out_ready = 1'b0;
      tick(); tick();
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_imm_ext", bus.imm_ext, 32'd0);
      chk("rst_extendSelect", {31'd0, bus.extendSelect}, 32'd0);
      chk("rst_bubble_cnt", {24'd0, bubble_cnt}, 32'd0);
      rst = 1'b0;
      tick();

      // 1: addi, latency 1
      bus.out_ready = 1'b1;
      send(32'h2008FFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
      bus.in_valid = 1'b0;
      chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t1_imm_ext", bus.imm_ext, 32'hFFFFFFFF);
      tick();

      // 2: decode table, back-to-back
      send(32'h35088000, 1'b0, 32'h00008000, 1'b1);  // ori
      send(32'h3C081234, 1'b0, 32'h12340000, 1'b1);  // lui
      send(32'h3108F0F0, 1'b0, 32'h0000F0F0, 1'b1);  // andi
      send(32'h3908ABCD, 1'b0, 32'h0000ABCD, 1'b1);  // xori
      send(32'hAD09FFF0, 1'b1, 32'hFFFFFFF0, 1'b1);  // sw
      send(32'h11098000, 1'b1, 32'hFFFF8000, 1'b1);  // beq
      send(32'h20097FFF, 1'b1, 32'h00007FFF, 1'b1);  // addi, positive max
      bus.in_valid = 1'b0;
      tick(); tick();

      // 3: load-use hazard, rs=9 rt=8
      bus.out_ready = 1'b0;
      send(32'h21280005, 1'b1, 32'h00000005, 1'b1);
      bus.in_valid = 1'b0;
      chk("t3_held_valid", {31'd0, bus.out_valid}, 32'd1);
      ex_memRead = 1'b1; ex_rt = 5'd0; #1;
      chk("t3_r0_no_hazard", {31'd0, bus.out_valid}, 32'd1);
      ex_rt = 5'd9; #1;
      chk("t3_rs_hazard_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("t3_rs_hazard_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      chk("t3_bubble_1", {24'd0, bubble_cnt}, 32'd1);
      ex_rt = 5'd8; #1;
      chk("t3_rt_hazard_valid", {31'd0, bus.out_valid}, 32'd0);
      ex_memRead = 1'b0; #1;
      chk("t3_clear_valid", {31'd0, bus.out_valid}, 32'd1);
      tick();
      chk("t3_bubble_still_1", {24'd0, bubble_cnt}, 32'd1);

      // 4: backpressure then drain+refill in one cycle
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("t4_imm_stable", bus.imm_ext, 32'h00000005);
         chk("t4_valid_stable", {31'd0, bus.out_valid}, 32'd1);
      end
      bus.out_ready = 1'b1;
      send(32'h35080042, 1'b0, 32'h00000042, 1'b1);
      bus.in_valid = 1'b0;
      chk("t4_refill_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t4_refill_imm", bus.imm_ext, 32'h00000042);
      tick(); tick();

      // 5: flush drops held and incoming
      bus.out_ready = 1'b0;
      send(32'h20080001, 1'b1, 32'h00000001, 1'b0);
      bus.in_valid = 1'b1; bus.instr = 32'h20080777; flush = 1'b1;
      tick();
      flush = 1'b0; bus.in_valid = 1'b0;
      chk("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.out_ready = 1'b1;
      tick(); tick(); tick();

      // 6: reset while held, then counter saturation
      bus.out_ready = 1'b0;
      send(32'h20081111, 1'b1, 32'h00001111, 1'b0);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("t6_rst_imm", bus.imm_ext, 32'd0);
      chk("t6_rst_bubble", {24'd0, bubble_cnt}, 32'd0);
      send(32'h21280005, 1'b1, 32'h00000005, 1'b1);
      bus.in_valid = 1'b0;
      ex_memRead = 1'b1; ex_rt = 5'd9;
      for (int i = 0; i < 254; i++) tick();
      chk("t6_bubble_254", {24'd0, bubble_cnt}, 32'd254);
      for (int i = 0; i < 46; i++) tick();
      chk("t6_bubble_sat", {24'd0, bubble_cnt}, 32'd255);
      ex_memRead = 1'b0;
      bus.out_ready = 1'b1;
      tick(); tick(); tick();

      chk("queue_empty", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
